// File: rtl/constants_pkg.sv
// Architectural size defaults shared by the core.
package constants_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int INST_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
endpackage

// File: rtl/instruction_pkg.sv
// Decoded-instruction bundle and RV32 opcode constants.
package instruction_pkg;
  import constants_pkg::*;

  localparam int REG_IDX_W = $clog2(REG_FILE_LEN);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                 valid;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic                 is_r;
    logic                 is_i;
    logic                 is_s;
    logic                 is_u;
    logic                 is_b;
    logic                 is_j;
    logic                 is_mul;
    logic [REG_IDX_W-1:0] src_reg_1;
    logic [REG_IDX_W-1:0] src_reg_2;
    logic [REG_IDX_W-1:0] dst_reg;
    logic [ARCH_LEN-1:0]  imm;
    logic [ARCH_LEN-1:0]  src_data_1;
    logic [ARCH_LEN-1:0]  src_data_2;
    logic                 reg_write_enable;
    logic                 reg_data_ready;
    logic [ARCH_LEN-1:0]  dst_reg_data;
  } inst_decoded_t;
endpackage

// File: rtl/decode_bypass_stage_operand_sel.sv
// Youngest-first operand select over in-flight producers.
module operand_bypass_sel
  import instruction_pkg::*;
#(
  parameter int ARCH_LEN     = constants_pkg::ARCH_LEN,
  parameter int REG_FILE_LEN = constants_pkg::REG_FILE_LEN,
  parameter int NUM_BYPASS   = 3,
  localparam int RW          = $clog2(REG_FILE_LEN)
) (
  input  logic [RW-1:0]                   src,
  input  logic [ARCH_LEN-1:0]             rf_data,
  input  inst_decoded_t [NUM_BYPASS-1:0]  bypass_in,
  output logic [ARCH_LEN-1:0]             data,
  output logic                            hazard
);

  logic unused_byp;
  assign unused_byp = ^bypass_in;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    data   = (src == '0) ? '0 : rf_data;
    hazard = 1'b0;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (bypass_in[k].valid &&
          bypass_in[k].reg_write_enable &&
          bypass_in[k].dst_reg == src &&
          src != '0) begin
        data   = bypass_in[k].dst_reg_data;
        hazard = ~bypass_in[k].reg_data_ready;
      end
    end
  end

endmodule

// File: rtl/decode_bypass_stage.sv
// RV32I/M decode with operand bypass, hazard stall and output register.
module decode_bypass_stage
  import instruction_pkg::*;
#(
  parameter int ARCH_LEN     = constants_pkg::ARCH_LEN,
  parameter int INST_LEN     = constants_pkg::INST_LEN,
  parameter int REG_FILE_LEN = constants_pkg::REG_FILE_LEN,
  parameter int NUM_BYPASS   = 3,
  parameter int STALL_CNT_W  = 16,
  localparam int RW          = $clog2(REG_FILE_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inst_valid_in,
  input  logic [INST_LEN-1:0]            inst_fetched_in,
  input  logic                           stall_in,
  input  logic                           flush_in,
  input  inst_decoded_t [NUM_BYPASS-1:0] bypass_in,
  output logic [RW-1:0]                  rf_src_reg_1,
  output logic [RW-1:0]                  rf_src_reg_2,
  input  logic [ARCH_LEN-1:0]            rf_src_data_1,
  input  logic [ARCH_LEN-1:0]            rf_src_data_2,
  output logic                           stall_dec_out,
  output inst_decoded_t                  inst_dec_out,
  output logic [STALL_CNT_W-1:0]         stall_cycles_out
);

  logic [INST_LEN-1:0] ins;
  logic [6:0]          op;
  logic [ARCH_LEN-1:0] data_1, data_2;
  logic                hz_1, hz_2;
  logic                use_1, use_2;
  logic                hazard;
  inst_decoded_t       dec;

  assign ins          = inst_fetched_in;
  assign op           = ins[6:0];
  assign rf_src_reg_1 = ins[19:15];
  assign rf_src_reg_2 = ins[24:20];

  operand_bypass_sel #(
    .ARCH_LEN     (ARCH_LEN),
    .REG_FILE_LEN (REG_FILE_LEN),
    .NUM_BYPASS   (NUM_BYPASS)
  ) u_sel_1 (
    .src       (rf_src_reg_1),
    .rf_data   (rf_src_data_1),
    .bypass_in (bypass_in),
    .data      (data_1),
    .hazard    (hz_1)
  );

  operand_bypass_sel #(
    .ARCH_LEN     (ARCH_LEN),
    .REG_FILE_LEN (REG_FILE_LEN),
    .NUM_BYPASS   (NUM_BYPASS)
  ) u_sel_2 (
    .src       (rf_src_reg_2),
    .rf_data   (rf_src_data_2),
    .bypass_in (bypass_in),
    .data      (data_2),
    .hazard    (hz_2)
  );

  always_comb begin
    dec            = '0;
    dec.valid      = inst_valid_in;
    dec.opcode     = op;
    dec.func3      = ins[14:12];
    dec.func7      = ins[31:25];
    dec.src_reg_1  = ins[19:15];
    dec.src_reg_2  = ins[24:20];
    dec.dst_reg    = ins[11:7];
    dec.is_r       = (op == OP_REG);
    dec.is_i       = (op == OP_IMM) | (op == OP_LOAD) | (op == OP_JALR);
    dec.is_s       = (op == OP_STORE);
    dec.is_u       = (op == OP_LUI) | (op == OP_AUIPC);
    dec.is_b       = (op == OP_BRANCH);
    dec.is_j       = (op == OP_JAL);
    dec.is_mul     = dec.is_r & (ins[31:25] == 7'b0000001);
    dec.reg_write_enable = (dec.is_r | dec.is_i | dec.is_u | dec.is_j)
                         & (ins[11:7] != '0);
    unique case (1'b1)
      dec.is_i: dec.imm = {{20{ins[31]}}, ins[31:20]};
      dec.is_s: dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      dec.is_b: dec.imm = {{19{ins[31]}}, ins[31], ins[7],
                           ins[30:25], ins[11:8], 1'b0};
      dec.is_u: dec.imm = {ins[31:12], 12'b0};
      dec.is_j: dec.imm = {{11{ins[31]}}, ins[31], ins[19:12],
                           ins[20], ins[30:21], 1'b0};
      default:  dec.imm = '0;
    endcase
    dec.src_data_1 = data_1;
    dec.src_data_2 = data_2;
  end

  assign use_1  = (dec.is_r | dec.is_i | dec.is_s | dec.is_b) & ~dec.is_u;
  assign use_2  = dec.is_r | dec.is_s | dec.is_b;
  assign hazard = inst_valid_in & ((use_1 & hz_1) | (use_2 & hz_2));

  assign stall_dec_out = rst & ~flush_in & (stall_in | hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_dec_out <= '0;
    end else if (flush_in) begin
      inst_dec_out.valid <= 1'b0;
    end else if (stall_in) begin
      inst_dec_out <= inst_dec_out;
    end else if (hazard) begin
      inst_dec_out <= '0;
    end else begin
      inst_dec_out <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_out <= '0;
    end else if (hazard & ~stall_in & ~flush_in & ~&stall_cycles_out) begin
      stall_cycles_out <= stall_cycles_out + STALL_CNT_W'(1);
    end
  end

endmodule
